// File: rtl/fd_pkg.sv
// Shared constants and helpers for the multi-channel frequency divider.
// Latency: n/a (package only).
// Backpressure: n/a.
package fd_pkg;

    // Default half-period counter width.
    localparam int FD_DIV_W    = 25;
    // 10 kHz output from a 50 MHz clock.
    localparam int FD_DEF_HALF = 2500;
    // Width of the channel index on the write port.
    localparam int FD_CH_W     = 4;

    // Half-period in clk cycles for a wanted output frequency, never below 1.
    function automatic int half_count(input int clk_hz, input int out_hz);
        int r;
        r = clk_hz / (2 * out_hz);
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fd_chan.sv
// One divider channel: half-period counter, active/shadow half-period, 50% clock and tick.
// Latency: clk_out/tick registered; first rising edge H cycles after enable or sync.
// Backpressure: none; a pending shadow commits only at a wrap, on sync, or while disabled.
// Optional FD_TICK_BOTH_EDGES_EN adds a falling-edge strobe.
module fd_chan
    import fd_pkg::*;
#(
    parameter int DIV_W    = FD_DIV_W,
    parameter int DEF_HALF = FD_DEF_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_val,
    input  logic             sync,
    output logic             clk_out,
`ifdef FD_TICK_BOTH_EDGES_EN
    output logic             tick_fall,
`endif
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DEF_H = DIV_W'(DEF_HALF);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] h;
    logic [DIV_W-1:0] s;
    logic             pending;
    logic             wrap;
    logic             commit;

    // A wrap ends a half-period; committing only there keeps every half-period whole.
    assign wrap   = en && !sync && (cnt == h - ONE);
    assign commit = sync || !en || wrap;

    // Counter, output toggle, edge strobes and shadow/active half-period handling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            h         <= DEF_H;
            s         <= DEF_H;
            pending   <= 1'b0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
`ifdef FD_TICK_BOTH_EDGES_EN
            tick_fall <= 1'b0;
`endif
        end else begin
            tick      <= 1'b0;
`ifdef FD_TICK_BOTH_EDGES_EN
            tick_fall <= 1'b0;
`endif
            if (sync || !en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (wrap) begin
                cnt       <= '0;
                clk_out   <= ~clk_out;
                tick      <= ~clk_out;
`ifdef FD_TICK_BOTH_EDGES_EN
                tick_fall <= clk_out;
`endif
            end else begin
                cnt <= cnt + ONE;
            end

            if (commit && pending) begin
                h <= s;
            end

            // A write coinciding with sync becomes active immediately.
            if (wr) begin
                s <= wr_val;
                if (sync) begin
                    h       <= wr_val;
                    pending <= 1'b0;
                end else begin
                    pending <= 1'b1;
                end
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fd_multi_tick.sv
// Multi-channel programmable divider: write decode, cfg_err, and NUM_CH fd_chan instances.
// Latency: cfg_err one cycle after a rejected load; outputs registered per channel.
// Backpressure: none; rejected writes (zero value or out-of-range channel) only pulse cfg_err.
// Optional FD_TICK_BOTH_EDGES_EN adds the tick_fall output.
module fd_multi_tick
    import fd_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = FD_DIV_W,
    parameter int DEF_HALF = half_count(CLK_HZ, 10_000)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  en,
    input  logic               load,
    input  logic [FD_CH_W-1:0] load_ch,
    input  logic [DIV_W-1:0]   load_val,
    input  logic               sync,
    output logic [NUM_CH-1:0]  clk_out,
`ifdef FD_TICK_BOTH_EDGES_EN
    output logic [NUM_CH-1:0]  tick_fall,
`endif
    output logic [NUM_CH-1:0]  tick,
    output logic               cfg_err
);

    // One extra bit so NUM_CH = 16 is representable.
    localparam logic [FD_CH_W:0] NUM_CH_L = (FD_CH_W + 1)'(NUM_CH);

    logic wr_ok;

    assign wr_ok = load && (load_val != '0) && ({1'b0, load_ch} < NUM_CH_L);

    // Flag rejected writes with a single registered pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= load && !wr_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        fd_chan #(
            .DIV_W    (DIV_W),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (en[i]),
            .wr        (wr_ok && (load_ch == FD_CH_W'(i))),
            .wr_val    (load_val),
            .sync      (sync),
            .clk_out   (clk_out[i]),
`ifdef FD_TICK_BOTH_EDGES_EN
            .tick_fall (tick_fall[i]),
`endif
            .tick      (tick[i])
        );
    end

endmodule
